// File: rtl/dma_io_requester.sv
// dma_io_requester: 8237A DREQ/DACK peripheral endpoint with TX/RX byte FIFOs
module dma_io_requester #(
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic                     Dir,
  input  logic                     DemandMode,
  output logic                     DREQ,
  input  logic                     DACK,
  input  logic                     nIOR,
  input  logic                     nIOW,
  input  logic                     nEOP,
  input  logic [7:0]               DataIn,
  output logic [7:0]               DataOut,
  output logic                     DataOE,
  input  logic                     LocPush,
  input  logic [7:0]               LocPushData,
  input  logic                     LocPop,
  output logic [7:0]               LocPopData,
  output logic [$clog2(DEPTH):0]   TxCount,
  output logic [$clog2(DEPTH):0]   RxCount,
  output logic                     TcDone,
  output logic                     Err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t state_q, state_d;
  logic dreq_q, dreq_d, tc_q, tc_d, err_q, err_d, arm_q, arm_d;
  logic nior_q, nior_d, niow_q, niow_d;
  logic [7:0] din_q, din_d;
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0] tx_mem_q [DEPTH];
  logic [7:0] rx_mem_q [DEPTH];
  logic ior_ev, iow_ev, tx_empty, tx_full, rx_empty, rx_full;
  logic tx_wr, tx_rd, rx_wr, rx_rd, open, cont;
  // Strobe rising-edge detection, FIFO bookkeeping and sticky error
  always_comb begin
    nior_d   = nIOR;
    niow_d   = nIOW;
    din_d    = nIOW ? din_q : DataIn;
    ior_ev   = DACK & !Dir & !nior_q & nIOR;
    iow_ev   = DACK & Dir & !niow_q & nIOW;
    tx_empty = tx_cnt_q == '0;
    tx_full  = tx_cnt_q == CW'(DEPTH);
    rx_empty = rx_cnt_q == '0;
    rx_full  = rx_cnt_q == CW'(DEPTH);
    tx_wr    = LocPush & !tx_full;
    tx_rd    = ior_ev & !tx_empty;
    rx_wr    = iow_ev & !rx_full;
    rx_rd    = LocPop & !rx_empty;
    tx_cnt_d = tx_cnt_q + CW'(tx_wr) - CW'(tx_rd);
    rx_cnt_d = rx_cnt_q + CW'(rx_wr) - CW'(rx_rd);
    tx_wp_d  = tx_wp_q + AW'(tx_wr);
    tx_rp_d  = tx_rp_q + AW'(tx_rd);
    rx_wp_d  = rx_wp_q + AW'(rx_wr);
    rx_rp_d  = rx_rp_q + AW'(rx_rd);
    err_d    = err_q | (LocPush & tx_full) | (ior_ev & tx_empty) | (iow_ev & rx_full) | (LocPop & rx_empty);
  end
  // Request FSM: open on threshold, hold while data/space remains, terminate on nEOP
  always_comb begin
    open    = Dir ? (CW'(DEPTH) - rx_cnt_q >= CW'(THRESH)) : (tx_cnt_q >= CW'(THRESH));
    cont    = Dir ? (rx_cnt_d != CW'(DEPTH)) : (tx_cnt_d != '0);
    state_d = state_q;
    dreq_d  = dreq_q;
    tc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        dreq_d = 1'b0;
        if (Enable & arm_q & open) begin
          state_d = REQ;
          dreq_d  = 1'b1;
        end
      end
      REQ, XFER: begin
        if (DACK & !nEOP) begin
          state_d = DONE;
          dreq_d  = 1'b0;
        end else if (DACK) begin
          state_d = XFER;
          if ((ior_ev | iow_ev) & (!DemandMode | !cont)) dreq_d = 1'b0;
        end else if (state_q == XFER || !Enable) begin
          state_d = IDLE;
          dreq_d  = 1'b0;
        end
      end
      DONE: begin
        dreq_d = 1'b0;
        if (!DACK) begin
          state_d = IDLE;
          tc_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    arm_d = !Enable | (arm_q & !(state_d == DONE && state_q != DONE));
  end
  // Control and pointer registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      dreq_q   <= 1'b0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
      arm_q    <= 1'b1;
      nior_q   <= 1'b1;
      niow_q   <= 1'b1;
      din_q    <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      dreq_q   <= dreq_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
      arm_q    <= arm_d;
      nior_q   <= nior_d;
      niow_q   <= niow_d;
      din_q    <= din_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end
  // FIFO storage
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      if (tx_wr) tx_mem_q[tx_wp_q] <= LocPushData;
      if (rx_wr) rx_mem_q[rx_wp_q] <= din_q;
    end
  end
  assign DREQ       = dreq_q;
  assign TcDone     = tc_q;
  assign Err        = err_q;
  assign TxCount    = tx_cnt_q;
  assign RxCount    = rx_cnt_q;
  assign DataOut    = tx_empty ? 8'hFF : tx_mem_q[tx_rp_q];
  assign LocPopData = rx_mem_q[rx_rp_q];
  assign DataOE     = DACK & !nIOR & !Dir;
endmodule
